// File: rtl/maxnet_feeder_pkg.sv
// Shared definitions for the maxnet front end and the maxfinder stage.
package maxnet_pkg;

  localparam int unsigned DW        = 5;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned CW        = 3;

  typedef logic [DW-1:0] sample_t;
  typedef logic [1:0]    state_t;

  localparam state_t ST_FILL  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

endpackage

// File: rtl/maxnet_feeder_if.sv
// Bundle of the upstream, maxfinder and consumer handshakes of the feeder.
interface maxnet_feeder_if;
  import maxnet_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  sample_t eps_in;
  logic    mf_start;
  sample_t mf_x1;
  sample_t mf_x2;
  sample_t mf_x3;
  sample_t mf_x4;
  sample_t mf_eps;
  logic    mf_done;
  sample_t mf_result;
  logic    out_valid;
  logic    out_ready;
  sample_t out_data;
  logic [1:0] out_idx;
  logic    out_nomatch;
  logic    err_timeout;

  // Feeder side.
  modport slave (
    input  in_valid, in_data, eps_in, mf_done, mf_result, out_ready,
    output in_ready, mf_start, mf_x1, mf_x2, mf_x3, mf_x4, mf_eps,
    output out_valid, out_data, out_idx, out_nomatch, err_timeout
  );

  // Environment side (upstream, maxfinder and consumer).
  modport master (
    output in_valid, in_data, eps_in, mf_done, mf_result, out_ready,
    input  in_ready, mf_start, mf_x1, mf_x2, mf_x3, mf_x4, mf_eps,
    input  out_valid, out_data, out_idx, out_nomatch, err_timeout
  );

endinterface

// File: rtl/maxnet_feeder_argmax.sv
// Finds the lowest frame slot holding a given value (bitwise equality only).
module maxnet_argmax
  import maxnet_pkg::*;
(
  input  sample_t    x1,
  input  sample_t    x2,
  input  sample_t    x3,
  input  sample_t    x4,
  input  sample_t    v,
  output logic [1:0] idx,
  output logic       nomatch
);

  // Priority search from slot 0 upward; no match reports index 0.
  always_comb begin
    idx     = 2'd0;
    nomatch = 1'b0;
    if (x1 == v) begin
      idx = 2'd0;
    end else if (x2 == v) begin
      idx = 2'd1;
    end else if (x3 == v) begin
      idx = 2'd2;
    end else if (x4 == v) begin
      idx = 2'd3;
    end else begin
      idx     = 2'd0;
      nomatch = 1'b1;
    end
  end

endmodule

// File: rtl/maxnet_feeder.sv
// Frames 4-sample groups for maxfinder, runs one start/done exchange per
// frame and returns the winner with its slot index over valid/ready.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  maxnet_feeder_if.slave  bus
);

  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The wait counter is cleared in START and steps once per WAIT cycle; the
  // abandon decision is taken when it reaches TIMEOUT-2 so that the
  // registered err_timeout pulse lands exactly TIMEOUT cycles after START.
  localparam logic [WW-1:0] TO_LAST  = WW'((TIMEOUT < 2) ? 0 : TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  sample_t       slot_q [4];
  sample_t       slot_d [4];
  sample_t       eps_q, eps_d;
  sample_t       res_q, res_d;
  logic [1:0]    idx_q, idx_d;
  logic          nomatch_q, nomatch_d;
  logic          err_q, err_d;
  logic          in_ready_s;
  logic          accept_s;
  logic [1:0]    am_idx_s;
  logic          am_nomatch_s;

  maxnet_argmax u_argmax (
    .x1      (slot_q[0]),
    .x2      (slot_q[1]),
    .x3      (slot_q[2]),
    .x4      (slot_q[3]),
    .v       (bus.mf_result),
    .idx     (am_idx_s),
    .nomatch (am_nomatch_s)
  );

  // Upstream backpressure: open while filling or prefilling, held low in reset.
  always_comb begin
    in_ready_s = 1'b0;
    if ((state_q == ST_FILL) || (state_q == ST_OUT)) begin
      in_ready_s = rst_n & (cnt_q < CNT_FULL);
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Next-state, slot capture and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    slot_d    = slot_q;
    eps_d     = eps_q;
    res_d     = res_q;
    idx_d     = idx_q;
    nomatch_d = nomatch_q;
    err_d     = 1'b0;
    accept_s  = bus.in_valid & in_ready_s;

    if (accept_s) begin
      slot_d[cnt_q[1:0]] = bus.in_data;
      cnt_d              = cnt_q + 3'd1;
      if (cnt_q == 3'd0) begin
        eps_d = bus.eps_in;
      end else begin
        eps_d = eps_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_FILL: begin
        if (cnt_d == CNT_FULL) begin
          state_d = ST_START;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_START: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mf_done) begin
          res_d     = bus.mf_result;
          idx_d     = am_idx_s;
          nomatch_d = am_nomatch_s;
          cnt_d     = 3'd0;
          state_d   = ST_OUT;
        end else if (wait_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = ST_FILL;
        end else begin
          wait_d  = wait_q + WW'(1);
          state_d = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (cnt_d == CNT_FULL) begin
            state_d = ST_START;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      wait_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
      eps_q     <= '0;
      res_q     <= '0;
      idx_q     <= 2'd0;
      nomatch_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      slot_q    <= slot_d;
      eps_q     <= eps_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      nomatch_q <= nomatch_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.mf_start    = (state_q == ST_START);
  assign bus.mf_x1       = slot_q[0];
  assign bus.mf_x2       = slot_q[1];
  assign bus.mf_x3       = slot_q[2];
  assign bus.mf_x4       = slot_q[3];
  assign bus.mf_eps      = eps_q;
  assign bus.out_valid   = (state_q == ST_OUT);
  assign bus.out_data    = res_q;
  assign bus.out_idx     = idx_q;
  assign bus.out_nomatch = nomatch_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder; the bench plays upstream, maxfinder and consumer.
module tb_maxnet_feeder;

  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   starts = 0;

  maxnet_feeder_if bus();

  maxnet_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count mf_start cycles.
  always @(posedge clk) begin
    if (bus.mf_start === 1'b1) starts <= starts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample; returns at the negedge after it was accepted.
  task automatic push(input logic [4:0] d, input logic [4:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.eps_in   = e;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input logic [4:0] a, b, c, d, e);
    push(a, e);
    push(b, 5'h03);
    push(c, 5'h03);
    push(d, 5'h03);
  endtask

  // Called in the START cycle: done one WAIT cycle later, returns in OUT.
  task automatic complete(input logic [4:0] r);
    @(negedge clk);
    bus.mf_done   = 1'b1;
    bus.mf_result = r;
    @(negedge clk);
    bus.mf_done   = 1'b0;
    bus.mf_result = 5'h00;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [4:0] d, input logic [1:0] i, input logic nm);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(d));
    check({tag, "_idx"}, 32'(bus.out_idx), 32'(i));
    check({tag, "_nomatch"}, 32'(bus.out_nomatch), 32'(nm));
  endtask

  initial begin
    logic [4:0] smp [8];
    int k;
    int n;
    logic held_ok;
    bus.in_valid = 1'b0; bus.in_data = 5'h00; bus.eps_in = 5'h00;
    bus.mf_done = 1'b0; bus.mf_result = 5'h00; bus.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mf_start", 32'(bus.mf_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // 1 Basic frame
    frame(5'h06, 5'h08, 5'h04, 5'h02, 5'h1E);
    check("t1_start", 32'(bus.mf_start), 32'd1);
    check("t1_x1", 32'(bus.mf_x1), 32'h06);
    check("t1_x2", 32'(bus.mf_x2), 32'h08);
    check("t1_x3", 32'(bus.mf_x3), 32'h04);
    check("t1_x4", 32'(bus.mf_x4), 32'h02);
    check("t1_eps", 32'(bus.mf_eps), 32'h1E);
    check("t1_wait_in_ready", 32'(bus.in_ready), 32'd0);
    complete(5'h08);
    check_out("t1", 5'h08, 2'd1, 1'b0);
    check("t1_one_start", 32'(starts), 32'd1);
    take();
    check("t1_released", 32'(bus.out_valid), 32'd0);

    // 2 Duplicates and no-match
    frame(5'h04, 5'h04, 5'h01, 5'h00, 5'h02);
    complete(5'h04);
    check_out("t2_dup", 5'h04, 2'd0, 1'b0);
    take();
    frame(5'h04, 5'h04, 5'h01, 5'h00, 5'h02);
    complete(5'h1F);
    check_out("t2_nm", 5'h1F, 2'd0, 1'b1);
    take();
    frame(5'h04, 5'h04, 5'h01, 5'h00, 5'h02);
    complete(5'h00);
    check_out("t2_last", 5'h00, 2'd3, 1'b0);
    take();

    // 3 Backpressure with prefill
    frame(5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h07);
    complete(5'h0C);
    smp = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};
    k = 0;
    held_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== 5'h0C || bus.out_idx !== 2'd2) held_ok = 1'b0;
      bus.in_valid = (k < 8);
      bus.in_data  = smp[k % 8];
      bus.eps_in   = (k == 0) ? 5'h05 : 5'h09;
      if (bus.in_ready === 1'b1 && k < 8) k++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("t3_held", 32'(held_ok), 32'd1);
    check("t3_accepted", 32'(k), 32'd4);
    check("t3_stall", 32'(bus.in_ready), 32'd0);
    check("t3_prefill_x4", 32'(bus.mf_x4), 32'h14);
    check("t3_prefill_eps", 32'(bus.mf_eps), 32'h05);
    take();
    check("t3_restart", 32'(bus.mf_start), 32'd1);
    complete(5'h14);
    check_out("t3", 5'h14, 2'd3, 1'b0);
    take();

    // 4 Timeout, then done exactly at the last WAIT cycle
    frame(5'h01, 5'h02, 5'h03, 5'h04, 5'h00);
    n = 0;
    held_ok = 1'b1;
    while (bus.err_timeout !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.out_valid !== 1'b0) held_ok = 1'b0;
    end
    check("t4_to_cycles", 32'(n), 32'(TIMEOUT));
    check("t4_no_valid", 32'(held_ok), 32'd1);
    check("t4_fill", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("t4_pulse", 32'(bus.err_timeout), 32'd0);
    frame(5'h01, 5'h02, 5'h03, 5'h04, 5'h00);
    repeat (TIMEOUT - 1) @(negedge clk);
    bus.mf_done = 1'b1;
    bus.mf_result = 5'h03;
    @(negedge clk);
    bus.mf_done = 1'b0;
    check("t4_done_wins_err", 32'(bus.err_timeout), 32'd0);
    check_out("t4_done_wins", 5'h03, 2'd2, 1'b0);
    take();

    // 5 Reset in WAIT
    frame(5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h0F);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_in_ready", 32'(bus.in_ready), 32'd0);
    check("t5_mf_x1", 32'(bus.mf_x1), 32'd0);
    check("t5_mf_eps", 32'(bus.mf_eps), 32'd0);
    check("t5_out_data", 32'(bus.out_data), 32'd0);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    bus.mf_done = 1'b1;
    bus.mf_result = 5'h1B;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mf_done = 1'b0;
    check("t5_done_ignored", 32'(bus.out_valid), 32'd0);
    check("t5_fill", 32'(bus.in_ready), 32'd1);
    frame(5'h09, 5'h1D, 5'h09, 5'h02, 5'h01);
    complete(5'h1D);
    check_out("t5_after", 5'h1D, 2'd1, 1'b0);
    take();

    // 6 Stray done in FILL
    push(5'h10, 5'h02);
    push(5'h07, 5'h03);
    bus.mf_done = 1'b1;
    bus.mf_result = 5'h07;
    @(negedge clk);
    bus.mf_done = 1'b0;
    check("t6_no_valid", 32'(bus.out_valid), 32'd0);
    check("t6_no_start", 32'(bus.mf_start), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    push(5'h05, 5'h03);
    push(5'h07, 5'h03);
    check("t6_start", 32'(bus.mf_start), 32'd1);
    complete(5'h07);
    check_out("t6", 5'h07, 2'd1, 1'b0);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
